axil_reg_slave: RTL and testbench

AXI4-Lite responder exposing a bank of 32-bit read/write control registers to fabric logic. Sits behind the AXI4-Lite control port and answers `WriteReg`/`ReadReg` traffic from the bench or processor. It accepts address and data channels independently, in either order, and commits byte-strobed writes. Each commit raises a per-register one-cycle pulse so downstream logic can react to software writes.

---
 rtl/axil_reg_slave.sv | 173 +++++++++++++++++
 tb/tb_axil_reg_slave.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_reg_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axil_reg_slave                                                           |
// | AXI4-Lite responder for a bank of 32-bit byte-strobed control registers. |
// | Optional macro AXIL_REG_SLVERR_EN: out-of-range accesses answer SLVERR.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module axil_reg_slave #(
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_REGS   = 16
) (
    input  logic                     axilite_clk,
    input  logic                     axilite_resetn,
    input  logic [ADDR_WIDTH-1:0]    s_axil_awaddr,
    input  logic [2:0]               s_axil_awprot,
    input  logic                     s_axil_awvalid,
    output logic                     s_axil_awready,
    input  logic [31:0]              s_axil_wdata,
    input  logic [3:0]               s_axil_wstrb,
    input  logic                     s_axil_wvalid,
    output logic                     s_axil_wready,
    output logic [1:0]               s_axil_bresp,
    output logic                     s_axil_bvalid,
    input  logic                     s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]    s_axil_araddr,
    input  logic [2:0]               s_axil_arprot,
    input  logic                     s_axil_arvalid,
    output logic                     s_axil_arready,
    output logic [31:0]              s_axil_rdata,
    output logic [1:0]               s_axil_rresp,
    output logic                     s_axil_rvalid,
    input  logic                     s_axil_rready,
    output logic [32*NUM_REGS-1:0]   reg_q,
    output logic [NUM_REGS-1:0]      reg_wr_pulse
);

    localparam int                 c_IDX_W       = ADDR_WIDTH - 2;
    localparam logic [c_IDX_W:0]   c_NUM_REGS    = (c_IDX_W + 1)'(NUM_REGS);
    localparam logic [1:0]         c_RESP_OKAY   = 2'b00;
`ifdef AXIL_REG_SLVERR_EN
    localparam logic [1:0]         c_RESP_OOR    = 2'b10;
`else
    localparam logic [1:0]         c_RESP_OOR    = 2'b00;
`endif

    logic                   r_en;
    logic                   r_aw_held;
    logic                   r_w_held;
    logic [c_IDX_W-1:0]     r_aw_idx;
    logic [31:0]            r_wdata;
    logic [3:0]             r_wstrb;
    logic                   r_bvalid;
    logic [1:0]             r_bresp;
    logic                   r_rvalid;
    logic [31:0]            r_rdata;
    logic [1:0]             r_rresp;
    logic [31:0]            r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]    r_wr_pulse;

    logic                   w_aw_hs;
    logic                   w_w_hs;
    logic                   w_ar_hs;
    logic                   w_commit;
    logic                   w_aw_in_range;
    logic                   w_ar_in_range;
    logic [c_IDX_W-1:0]     w_ar_idx;
    logic [31:0]            w_rd_mux;
    logic                   w_unused;

    assign w_unused = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr[1:0], s_axil_araddr[1:0]};

    assign s_axil_awready = r_en & ~r_aw_held & ~r_bvalid;
    assign s_axil_wready  = r_en & ~r_w_held & ~r_bvalid;
    assign s_axil_arready = r_en & ~r_rvalid;
    assign s_axil_bvalid  = r_bvalid;
    assign s_axil_bresp   = r_bresp;
    assign s_axil_rvalid  = r_rvalid;
    assign s_axil_rdata   = r_rdata;
    assign s_axil_rresp   = r_rresp;
    assign reg_wr_pulse   = r_wr_pulse;

    assign w_aw_hs       = s_axil_awvalid & s_axil_awready;
    assign w_w_hs        = s_axil_wvalid & s_axil_wready;
    assign w_ar_hs       = s_axil_arvalid & s_axil_arready;
    // Both halves held and no response yet outstanding: commit exactly once.
    assign w_commit      = r_aw_held & r_w_held & ~r_bvalid;
    assign w_ar_idx      = s_axil_araddr[ADDR_WIDTH-1:2];
    assign w_aw_in_range = {1'b0, r_aw_idx} < c_NUM_REGS;
    assign w_ar_in_range = {1'b0, w_ar_idx} < c_NUM_REGS;

    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_ar_idx == c_IDX_W'(i)) begin
                w_rd_mux = r_regs[i];
            end
        end
    end

    always_ff @(posedge axilite_clk) begin
        if (!axilite_resetn) begin
            r_en      <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_idx  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_RESP_OKAY;
        end else begin
            r_en <= 1'b1;
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= s_axil_awaddr[ADDR_WIDTH-1:2];
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= s_axil_wdata;
                r_wstrb  <= s_axil_wstrb;
            end
            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_aw_in_range ? c_RESP_OKAY : c_RESP_OOR;
            end else if (r_bvalid && s_axil_bready) begin
                r_bvalid  <= 1'b0;
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end
        end
    end

    // Out-of-range indices match no register, so they are silently discarded.
    always_ff @(posedge axilite_clk) begin
        if (!axilite_resetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_commit && (r_aw_idx == c_IDX_W'(i))) begin
                    for (int k = 0; k < 4; k++) begin
                        if (r_wstrb[k]) begin
                            r_regs[i][8*k +: 8] <= r_wdata[8*k +: 8];
                        end
                    end
                    r_wr_pulse[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge axilite_clk) begin
        if (!axilite_resetn) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= c_RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_mux;
            r_rresp  <= w_ar_in_range ? c_RESP_OKAY : c_RESP_OOR;
        end else if (r_rvalid && s_axil_rready) begin
            r_rvalid <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_q
        assign reg_q[32*i +: 32] = r_regs[i];
    end

endmodule
`default_nettype wire

// File: tb/tb_axil_reg_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_axil_reg_slave                                                        |
// | Directed bench with a transaction-level reference model of the bank.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_axil_reg_slave;

    localparam int         AW   = 12;
    localparam int         NREG = 16;
`ifdef AXIL_REG_SLVERR_EN
    localparam logic [1:0] OOR  = 2'b10;
`else
    localparam logic [1:0] OOR  = 2'b00;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic [AW-1:0] awaddr = '0, araddr = '0;
    logic awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, bready = 1'b0, rready = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0] wstrb = '0;
    logic awready, wready, arready, bvalid, rvalid;
    logic [1:0] bresp, rresp;
    logic [31:0] rdata;
    logic [32*NREG-1:0] reg_q;
    logic [NREG-1:0] reg_wr_pulse;

    int total = 0;
    int bad = 0;
    logic chk_on = 1'b0;

    always #5 clk = ~clk;

    axil_reg_slave #(.ADDR_WIDTH(AW), .NUM_REGS(NREG)) dut (
        .axilite_clk(clk), .axilite_resetn(resetn),
        .s_axil_awaddr(awaddr), .s_axil_awprot(3'b000), .s_axil_awvalid(awvalid),
        .s_axil_awready(awready), .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
        .s_axil_wvalid(wvalid), .s_axil_wready(wready), .s_axil_bresp(bresp),
        .s_axil_bvalid(bvalid), .s_axil_bready(bready), .s_axil_araddr(araddr),
        .s_axil_arprot(3'b000), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid),
        .s_axil_rready(rready), .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
    );

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    // Reference model: transaction state advanced once per rising edge.
    logic        m_en = 0, m_aw_held = 0, m_w_held = 0, m_bvalid = 0, m_rvalid = 0;
    int          m_aw_idx = 0, m_pulse = -1, m_ridx = 0;
    logic [31:0] m_wdata = 0, m_rdata = 0;
    logic [3:0]  m_wstrb = 0;
    logic [1:0]  m_bresp = 0, m_rresp = 0;
    logic [31:0] m_regs [NREG];
    logic        m_awr, m_wr, m_arr, m_commit;

    initial for (int i = 0; i < NREG; i++) m_regs[i] = '0;

    always @(posedge clk) begin
        if (!resetn) begin
            m_en = 0; m_aw_held = 0; m_w_held = 0; m_bvalid = 0; m_rvalid = 0;
            m_pulse = -1; m_rdata = 0; m_bresp = 0; m_rresp = 0;
            for (int i = 0; i < NREG; i++) m_regs[i] = '0;
        end else begin
            m_awr    = m_en && !m_aw_held && !m_bvalid;
            m_wr     = m_en && !m_w_held && !m_bvalid;
            m_arr    = m_en && !m_rvalid;
            m_commit = m_aw_held && m_w_held && !m_bvalid;
            m_pulse  = -1;
            if (m_rvalid && rready) m_rvalid = 0;
            if (arvalid && m_arr) begin
                m_ridx   = int'(araddr[AW-1:2]);
                m_rvalid = 1;
                m_rdata  = (m_ridx < NREG) ? m_regs[m_ridx] : 32'h0;
                m_rresp  = (m_ridx < NREG) ? 2'b00 : OOR;
            end
            if (m_bvalid && bready) begin
                m_bvalid = 0; m_aw_held = 0; m_w_held = 0;
            end else if (m_commit) begin
                if (m_aw_idx < NREG) begin
                    for (int k = 0; k < 4; k++)
                        if (m_wstrb[k]) m_regs[m_aw_idx][8*k +: 8] = m_wdata[8*k +: 8];
                    m_pulse = m_aw_idx;
                end
                m_bvalid = 1;
                m_bresp  = (m_aw_idx < NREG) ? 2'b00 : OOR;
            end
            if (awvalid && m_awr) begin m_aw_held = 1; m_aw_idx = int'(awaddr[AW-1:2]); end
            if (wvalid && m_wr) begin m_w_held = 1; m_wdata = wdata; m_wstrb = wstrb; end
            m_en = 1;
        end
    end

    function automatic logic [32*NREG-1:0] model_flat();
        logic [32*NREG-1:0] f;
        for (int i = 0; i < NREG; i++) f[32*i +: 32] = m_regs[i];
        return f;
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            check("awready", awready, m_en && !m_aw_held && !m_bvalid);
            check("wready", wready, m_en && !m_w_held && !m_bvalid);
            check("arready", arready, m_en && !m_rvalid);
            check("bvalid", bvalid, m_bvalid);
            check("rvalid", rvalid, m_rvalid);
            if (m_bvalid) check("bresp", bresp, m_bresp);
            if (m_rvalid) begin
                check("rdata", rdata, m_rdata);
                check("rresp", rresp, m_rresp);
            end
            check("reg_q", reg_q, model_flat());
            check("reg_wr_pulse", reg_wr_pulse, (m_pulse >= 0) ? (NREG'(1) << m_pulse) : '0);
        end
    end

    task automatic aw_send(input logic [AW-1:0] a);
        int n = 0;
        awaddr = a; awvalid = 1;
        while (!awready && n < 200) begin @(negedge clk); n++; end
        if (!awready) timeout("aw");
        @(negedge clk); awvalid = 0;
    endtask

    task automatic w_send(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        wdata = d; wstrb = s; wvalid = 1;
        while (!wready && n < 200) begin @(negedge clk); n++; end
        if (!wready) timeout("w");
        @(negedge clk); wvalid = 0;
    endtask

    task automatic ar_send(input logic [AW-1:0] a);
        int n = 0;
        araddr = a; arvalid = 1;
        while (!arready && n < 200) begin @(negedge clk); n++; end
        if (!arready) timeout("ar");
        @(negedge clk); arvalid = 0;
    endtask

    task automatic b_take(output logic [1:0] resp);
        int n = 0;
        bready = 1;
        while (!bvalid && n < 200) begin @(negedge clk); n++; end
        if (!bvalid) timeout("b");
        resp = bresp;
        @(negedge clk); bready = 0;
    endtask

    task automatic r_take(output logic [31:0] d, output logic [1:0] resp);
        int n = 0;
        rready = 1;
        while (!rvalid && n < 200) begin @(negedge clk); n++; end
        if (!rvalid) timeout("r");
        d = rdata; resp = rresp;
        @(negedge clk); rready = 0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [1:0] resp);
        fork
            aw_send(a);
            w_send(d, s);
        join
        b_take(resp);
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp);
        ar_send(a);
        r_take(d, resp);
    endtask

    logic [31:0] d;
    logic [1:0]  r;
    logic [32*NREG-1:0] q_before;

    initial begin
        repeat (3) @(negedge clk);
        chk_on = 1;
        check("rst_awready", awready, 1'b0);
        check("rst_reg_q", reg_q, '0);
        check("rst_rdata", rdata, 32'h0);
        resetn = 1;
        @(negedge clk);
        check("en_after_release", awready, 1'b1);

        // Basic write then read of register 2
        fork aw_send(12'h008); w_send(32'hDEADBEEF, 4'hF); join
        check("t1_pulse_pre", reg_wr_pulse, 16'h0000);
        @(negedge clk);
        check("t1_pulse", reg_wr_pulse, 16'h0004);
        check("t1_reg_q2", reg_q[95:64], 32'hDEADBEEF);
        @(negedge clk);
        check("t1_pulse_post", reg_wr_pulse, 16'h0000);
        b_take(r);
        check("t1_bresp", r, 2'b00);
        rd(12'h008, d, r);
        check("t1_rdata", d, 32'hDEADBEEF);
        check("t1_rresp", r, 2'b00);

        // AW first, W five cycles later
        aw_send(12'h00C);
        repeat (5) begin check("t2_awready_held", awready, 1'b0); @(negedge clk); end
        w_send(32'h11223344, 4'hF);
        check("t2_bvalid_pre", bvalid, 1'b0);
        @(negedge clk);
        check("t2_bvalid", bvalid, 1'b1);
        b_take(r);
        // W first, AW five cycles later
        w_send(32'h55667788, 4'hF);
        repeat (5) @(negedge clk);
        aw_send(12'h014);
        check("t2b_bvalid_pre", bvalid, 1'b0);
        @(negedge clk);
        check("t2b_bvalid", bvalid, 1'b1);
        b_take(r);
        rd(12'h014, d, r);
        check("t2b_rdata", d, 32'h55667788);

        // Byte strobes on register 3
        wr(12'h00C, 32'hAABBCCDD, 4'b0101, r);
        rd(12'h00C, d, r);
        check("t3_strobe", d, 32'h11BB33DD);

        // Out-of-range access
        q_before = reg_q;
        wr(12'h040, 32'hFFFFFFFF, 4'hF, r);
        check("t4_bresp", r, OOR);
        check("t4_reg_q_same", reg_q, q_before);
        rd(12'h040, d, r);
        check("t4_rdata", d, 32'h0);
        check("t4_rresp", r, OOR);

        // Backpressure plus same-edge read of register being committed
        wr(12'h004, 32'h01010101, 4'hF, r);
        fork aw_send(12'h004); w_send(32'h5A5A5A5A, 4'hF); join
        ar_send(12'h004);
        repeat (10) begin
            check("t5_bvalid", bvalid, 1'b1);
            check("t5_rvalid", rvalid, 1'b1);
            check("t5_rdata_old", rdata, 32'h01010101);
            check("t5_awready", awready, 1'b0);
            check("t5_arready", arready, 1'b0);
            @(negedge clk);
        end
        b_take(r);
        r_take(d, r);
        check("t5_take_old", d, 32'h01010101);
        rd(12'h004, d, r);
        check("t5_new", d, 32'h5A5A5A5A);

        // Reset while a write response is pending
        fork aw_send(12'h000); w_send(32'hCAFEF00D, 4'hF); join
        @(negedge clk);
        check("t6_bvalid", bvalid, 1'b1);
        check("t6_reg0", reg_q[31:0], 32'hCAFEF00D);
        resetn = 0;
        @(negedge clk);
        check("t6_rst_bvalid", bvalid, 1'b0);
        check("t6_rst_reg_q", reg_q, '0);
        check("t6_rst_rdata", rdata, 32'h0);
        check("t6_rst_awready", awready, 1'b0);
        resetn = 1;
        @(negedge clk);
        wr(12'h014, 32'h12345678, 4'hF, r);
        check("t6_bresp", r, 2'b00);
        rd(12'h014, d, r);
        check("t6_rdata", d, 32'h12345678);

        repeat (2) @(negedge clk);
        chk_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
